// File: rtl/idli_sqi_ctrl.sv
// rtl/idli_sqi_ctrl.sv - single-access 16b SQI (quad SPI) memory controller
//
// Purpose: turns one core request into an SQI transaction made of an opcode,
// a 24b address, optional read turnaround and four data nibbles. The read
// data is streamed out slice by slice and assembled into a word.
//
// Ports:
//   i_clk, i_rst        core clock, synchronous active-high reset
//   i_req, o_ready      request handshake (accept = i_req && o_ready)
//   i_wr, i_addr,       access type, word address and write data,
//   i_wdata             all latched on accept
//   o_rslice,           read nibble presented combinationally from the bus,
//   o_rslice_vld,       its valid flag and its slice index
//   o_rctr
//   o_rdata             assembled read word, held between reads
//   o_done              one-cycle end-of-access pulse
//   o_sqi_cs_n          memory chip select (active low)
//   o_sqi_sck_en        memory clock gate enable
//   o_sqi_sio, o_sqi_oe SQI output nibble and its pad output enable
//   i_sqi_sio           SQI input nibble

module idli_sqi_ctrl #(
  parameter logic [7:0]  RD_CMD       = 8'hEB,
  parameter logic [7:0]  WR_CMD       = 8'h38,
  parameter int unsigned DUMMY_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  output logic        o_ready,
  input  logic        i_wr,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic [3:0]  o_rslice,
  output logic        o_rslice_vld,
  output logic [1:0]  o_rctr,
  output logic [15:0] o_rdata,
  output logic        o_done,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_sck_en,
  output logic [3:0]  o_sqi_sio,
  output logic        o_sqi_oe,
  input  logic [3:0]  i_sqi_sio
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [2:0] LP_DUMMY_LAST = 3'(DUMMY_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic        r_wr;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        w_accept;
  logic [7:0]  w_opcode;

  assign o_rdata = r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_wr    <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_rdata <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_wr    <= i_wr;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      // Each read nibble lands in the word slot named by its slice index.
      if (o_rslice_vld) begin
        r_rdata[{r_cnt[1:0], 2'b00} +: 4] <= i_sqi_sio;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = 3'd0;
    w_accept     = 1'b0;
    w_opcode     = r_wr ? WR_CMD : RD_CMD;
    o_ready      = 1'b0;
    o_done       = 1'b0;
    o_sqi_cs_n   = 1'b0;
    o_sqi_sck_en = 1'b1;
    o_sqi_oe     = 1'b0;
    o_sqi_sio    = 4'h0;
    o_rslice     = 4'h0;
    o_rslice_vld = 1'b0;
    o_rctr       = 2'd0;

    case (r_state)
      S_IDLE: begin
        o_ready      = 1'b1;
        o_sqi_cs_n   = 1'b1;
        o_sqi_sck_en = 1'b0;
        if (i_req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CMD;
        end
      end

      S_CMD: begin
        o_sqi_oe  = 1'b1;
        o_sqi_sio = (r_cnt == 3'd0) ? w_opcode[7:4] : w_opcode[3:0];
        if (r_cnt == 3'd1) begin
          w_state_nxt = S_ADDR;
        end
      end

      S_ADDR: begin
        // 24b address is {8'h00, r_addr}; the first two nibbles are zero.
        o_sqi_oe = 1'b1;
        case (r_cnt)
          3'd2:    o_sqi_sio = r_addr[15:12];
          3'd3:    o_sqi_sio = r_addr[11:8];
          3'd4:    o_sqi_sio = r_addr[7:4];
          3'd5:    o_sqi_sio = r_addr[3:0];
          default: o_sqi_sio = 4'h0;
        endcase
        if (r_cnt == 3'd5) begin
          w_state_nxt = r_wr ? S_DATA : S_DUMMY;
        end
      end

      S_DUMMY: begin
        if (r_cnt == LP_DUMMY_LAST) begin
          w_state_nxt = S_DATA;
        end
      end

      S_DATA: begin
        if (r_wr) begin
          o_sqi_oe  = 1'b1;
          o_sqi_sio = r_wdata[{r_cnt[1:0], 2'b00} +: 4];
        end else begin
          o_rslice     = i_sqi_sio;
          o_rslice_vld = 1'b1;
          o_rctr       = r_cnt[1:0];
        end
        if (r_cnt == 3'd3) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        o_done       = 1'b1;
        o_sqi_cs_n   = 1'b1;
        o_sqi_sck_en = 1'b0;
        w_state_nxt  = S_IDLE;
      end

      default: begin
        o_sqi_cs_n   = 1'b1;
        o_sqi_sck_en = 1'b0;
        w_state_nxt  = S_IDLE;
      end
    endcase

    // Phase counter restarts on every state entry and stays at 0 in IDLE.
    if ((w_state_nxt == r_state) && (r_state != S_IDLE)) begin
      w_cnt_nxt = r_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// tb/tb_idli_sqi_ctrl.sv - self-checking bench for idli_sqi_ctrl

module tb_idli_sqi_ctrl;

  localparam int D = 4;
  localparam logic [7:0] RD_OP = 8'hEB;
  localparam logic [7:0] WR_OP = 8'h38;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req = 1'b0;
  logic        i_wr = 1'b0;
  logic [15:0] i_addr = 16'h0;
  logic [15:0] i_wdata = 16'h0;
  logic [3:0]  i_sqi_sio = 4'h0;
  logic        o_ready, o_rslice_vld, o_done, o_sqi_cs_n, o_sqi_sck_en, o_sqi_oe;
  logic [3:0]  o_rslice, o_sqi_sio;
  logic [1:0]  o_rctr;
  logic [15:0] o_rdata;

  logic        i_req1 = 1'b0;
  logic [3:0]  i_sqi_sio1 = 4'h0;
  logic        o_ready1, o_rslice_vld1, o_done1, o_sqi_cs_n1, o_sqi_sck_en1, o_sqi_oe1;
  logic [3:0]  o_rslice1, o_sqi_sio1;
  logic [1:0]  o_rctr1;
  logic [15:0] o_rdata1;

  initial forever #5 clk = ~clk;

  idli_sqi_ctrl dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .o_ready(o_ready), .i_wr(i_wr),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_rslice(o_rslice), .o_rslice_vld(o_rslice_vld),
    .o_rctr(o_rctr), .o_rdata(o_rdata), .o_done(o_done), .o_sqi_cs_n(o_sqi_cs_n),
    .o_sqi_sck_en(o_sqi_sck_en), .o_sqi_sio(o_sqi_sio), .o_sqi_oe(o_sqi_oe),
    .i_sqi_sio(i_sqi_sio)
  );

  idli_sqi_ctrl #(.DUMMY_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req1), .o_ready(o_ready1), .i_wr(1'b0),
    .i_addr(16'h0000), .i_wdata(16'h0000), .o_rslice(o_rslice1), .o_rslice_vld(o_rslice_vld1),
    .o_rctr(o_rctr1), .o_rdata(o_rdata1), .o_done(o_done1), .o_sqi_cs_n(o_sqi_cs_n1),
    .o_sqi_sck_en(o_sqi_sck_en1), .o_sqi_sio(o_sqi_sio1), .o_sqi_oe(o_sqi_oe1),
    .i_sqi_sio(i_sqi_sio1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle bus picture of one access, listed from the cycle after accept.
  typedef struct packed {
    logic       ready;
    logic       cs_n;
    logic       sck;
    logic       oe;
    logic [3:0] sio;
    logic       vld;
    logic [1:0] rctr;
    logic       done;
  } rec_t;

  rec_t        exp_q[$];
  logic [15:0] m_rdata = 16'h0;
  logic [63:0] sio_log = 64'h0;
  int          cs_run = 0;
  int          last_gap = 0;
  bit          armed = 1'b0;

  task automatic build(input logic w, input logic [15:0] a, input logic [15:0] d);
    logic [31:0] hdr;
    rec_t r;
    hdr = {(w ? WR_OP : RD_OP), 8'h00, a};
    for (int i = 0; i < 8; i++) begin
      r = '0; r.sck = 1'b1; r.oe = 1'b1; r.sio = hdr[31-4*i -: 4];
      exp_q.push_back(r);
    end
    if (!w) begin
      for (int i = 0; i < D; i++) begin
        r = '0; r.sck = 1'b1;
        exp_q.push_back(r);
      end
    end
    for (int i = 0; i < 4; i++) begin
      r = '0; r.sck = 1'b1;
      if (w) begin
        r.oe = 1'b1; r.sio = d[4*i +: 4];
      end else begin
        r.vld = 1'b1; r.rctr = 2'(i);
      end
      exp_q.push_back(r);
    end
    r = '0; r.cs_n = 1'b1; r.done = 1'b1;
    exp_q.push_back(r);
  endtask

  always @(negedge clk) begin
    rec_t r;
    bit   was_idle;
    logic [3:0] exp_sl;
    if (armed) begin
      was_idle = (exp_q.size() == 0);
      if (was_idle) begin
        r = '0; r.ready = 1'b1; r.cs_n = 1'b1;
      end else begin
        r = exp_q.pop_front();
      end
      exp_sl = r.vld ? i_sqi_sio : 4'h0;
      chk("cycle", {o_ready, o_sqi_cs_n, o_sqi_sck_en, o_sqi_oe, o_sqi_sio, o_rslice_vld,
                    o_rslice, o_rctr, o_done, o_rdata},
                   {r.ready, r.cs_n, r.sck, r.oe, r.sio, r.vld, exp_sl, r.rctr, r.done, m_rdata});
      if (r.vld) m_rdata[int'(r.rctr)*4 +: 4] = i_sqi_sio;
      if (!i_rst && was_idle && i_req) begin
        build(i_wr, i_addr, i_wdata);
        sio_log = 64'h0;
      end
    end
    if (o_sqi_oe === 1'b1) sio_log = {sio_log[59:0], o_sqi_sio};
    if (o_sqi_cs_n === 1'b1) cs_run++;
    else if (o_sqi_cs_n === 1'b0) begin
      if (cs_run > 0) last_gap = cs_run;
      cs_run = 0;
    end
    if (i_rst) begin
      exp_q.delete();
      m_rdata = 16'h0;
      armed = 1'b1;
    end
  end

  logic [3:0] rd_nibs [4];

  task automatic run_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                            input bit keep, input bit tog, input bit plan,
                            output int lat, output int fv);
    int guard;
    guard = 0; lat = -1; fv = -1;
    i_req = 1'b1; i_wr = w; i_addr = a; i_wdata = d;
    @(negedge clk);
    while (!o_ready && guard < 50) begin
      @(posedge clk); #1;
      i_sqi_sio = 4'($urandom_range(0, 15));
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", 64'(guard < 50), 64'd1);
    @(posedge clk); #1;
    if (!keep) i_req = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (plan && j >= 8 + D && j < 12 + D) i_sqi_sio = rd_nibs[j-8-D];
      else i_sqi_sio = 4'($urandom_range(0, 15));
      if (tog) begin
        i_wr = ~i_wr; i_addr = 16'($urandom); i_wdata = 16'($urandom);
      end
      @(negedge clk);
      if (o_rslice_vld && fv < 0) fv = j + 1;
      if (o_done) begin
        lat = j + 1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, fv;
    rd_nibs[0] = 4'h5; rd_nibs[1] = 4'h6; rd_nibs[2] = 4'h7; rd_nibs[3] = 4'h8;
    i_rst = 1'b1; i_req = 1'b1; i_wr = 1'b1; i_addr = 16'h0F0F; i_wdata = 16'hBEEF;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_state", {o_ready, o_sqi_cs_n, o_sqi_sck_en, o_sqi_oe, o_sqi_sio, o_rslice_vld,
                      o_rslice, o_rctr, o_done, o_rdata}, {4'b1100, 28'h0});
    @(posedge clk); #1;
    i_rst = 1'b0;

    run_access(1'b1, 16'h0F0F, 16'hBEEF, 1'b0, 1'b0, 1'b0, lat, fv);
    chk("wr_after_rst_lat", 64'(lat), 64'd13);
    chk("wr_after_rst_rdata", 64'(o_rdata), 64'h0);

    run_access(1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, lat, fv);
    chk("rd_lat", 64'(lat), 64'd17);
    chk("rd_first_vld", 64'(fv), 64'd13);
    chk("rd_rdata", 64'(o_rdata), 64'h8765);
    chk("rd_sio_seq", sio_log, 64'hEB001234);

    run_access(1'b1, 16'hABCD, 16'hF00D, 1'b0, 1'b0, 1'b0, lat, fv);
    chk("wr_lat", 64'(lat), 64'd13);
    chk("wr_sio_seq", sio_log, 64'h3800ABCDD00F);
    chk("wr_rdata_kept", 64'(o_rdata), 64'h8765);

    i_req = 1'b1; i_wr = 1'b0; i_addr = 16'h1234;
    @(negedge clk);
    chk("abort_ready", 64'(o_ready), 64'd1);
    @(posedge clk); #1;
    i_req = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk);
    chk("abort_state", {o_ready, o_sqi_cs_n, o_done, o_rdata}, {3'b110, 16'h0});
    @(posedge clk); #1;
    run_access(1'b1, 16'h4321, 16'hCAFE, 1'b0, 1'b0, 1'b0, lat, fv);
    chk("abort_then_wr_lat", 64'(lat), 64'd13);

    run_access(1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, lat, fv);
    chk("b2b_first_lat", 64'(lat), 64'd17);
    run_access(1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, lat, fv);
    chk("b2b_second_lat", 64'(lat), 64'd17);
    chk("b2b_cs_gap", 64'(last_gap), 64'd2);

    run_access(1'b1, 16'h5A5A, 16'h1357, 1'b0, 1'b1, 1'b0, lat, fv);
    chk("toggle_wr_seq", sio_log, 64'h38005A5A7531);
    chk("toggle_wr_lat", 64'(lat), 64'd13);

    i_req1 = 1'b1;
    @(negedge clk);
    chk("d1_ready", 64'(o_ready1), 64'd1);
    @(posedge clk); #1;
    i_req1 = 1'b0;
    lat = -1; fv = -1;
    for (int j = 0; j < 40; j++) begin
      i_sqi_sio1 = 4'(j);
      @(negedge clk);
      if (o_rslice_vld1 && fv < 0) begin
        fv = j + 1;
        chk("d1_first_rctr", 64'(o_rctr1), 64'd0);
      end
      if (o_done1) begin
        lat = j + 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("d1_first_vld", 64'(fv), 64'd10);
    chk("d1_done_lat", 64'(lat), 64'd14);
    chk("d1_rdata", 64'(o_rdata1), 64'hCBA9);

    repeat (3) begin @(posedge clk); #1; end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
